// File: rtl/calc_polar_from_xy_15_pkg.sv
// Shared constants for the polar/Cartesian conversion blocks: angle grid,
// fixed-point scaling, FSM encodings and r_theta field positions.
package polar_consts;

  localparam int unsigned ANGLE_STEPS = 13;
  localparam int unsigned TRIG_SHIFT  = 8;

  localparam int unsigned XY_W   = 12;
  localparam int unsigned TRIG_W = 10;
  localparam int unsigned P_W    = 24;
  localparam int unsigned IDX_W  = 4;

  localparam int unsigned R_LSB  = 0;
  localparam int unsigned R_MSB  = 7;
  localparam int unsigned TH_LSB = 8;
  localparam int unsigned TH_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Scale a projection back to radius units and clamp to [0, rmax].
  function automatic logic [7:0] sat_r(input logic signed [P_W-1:0] p,
                                       input int unsigned            shift,
                                       input logic signed [P_W-1:0] rmax);
    logic signed [P_W-1:0] s;
    s = p >>> shift;
    if (s < 0)
      sat_r = '0;
    else if (s > rmax)
      sat_r = rmax[7:0];
    else
      sat_r = s[7:0];
  endfunction

endpackage

// File: rtl/calc_polar_from_xy_15_trig_lut.sv
// 15-degree cos/sin table, scaled by 256, for idx 0..12 (0..180 degrees).
module trig_lut_15
  import polar_consts::*;
(
  input  logic        [IDX_W-1:0]  idx_i,
  output logic signed [TRIG_W-1:0] cos_o,
  output logic signed [TRIG_W-1:0] sin_o
);

  always_comb begin
    cos_o = '0;
    sin_o = '0;
    unique case (idx_i)
      4'd0:  begin cos_o =  10'sd256; sin_o =  10'sd0;   end
      4'd1:  begin cos_o =  10'sd247; sin_o =  10'sd66;  end
      4'd2:  begin cos_o =  10'sd222; sin_o =  10'sd128; end
      4'd3:  begin cos_o =  10'sd181; sin_o =  10'sd181; end
      4'd4:  begin cos_o =  10'sd128; sin_o =  10'sd222; end
      4'd5:  begin cos_o =  10'sd66;  sin_o =  10'sd247; end
      4'd6:  begin cos_o =  10'sd0;   sin_o =  10'sd256; end
      4'd7:  begin cos_o = -10'sd66;  sin_o =  10'sd247; end
      4'd8:  begin cos_o = -10'sd128; sin_o =  10'sd222; end
      4'd9:  begin cos_o = -10'sd181; sin_o =  10'sd181; end
      4'd10: begin cos_o = -10'sd222; sin_o =  10'sd128; end
      4'd11: begin cos_o = -10'sd247; sin_o =  10'sd66;  end
      4'd12: begin cos_o = -10'sd256; sin_o =  10'sd0;   end
      default: begin cos_o = '0; sin_o = '0; end
    endcase
  end

endmodule

// File: rtl/calc_polar_from_xy_15.sv
// Cartesian (x, y>=0) to packed {theta_idx, r} by a 13-step search for the
// 15-degree angle that maximises x*cos + y*sin.
module calc_polar_from_xy_15
  import polar_consts::*;
#(
  parameter int unsigned COS_SCALE_SHIFT = 8,
  parameter int unsigned R_MAX           = 255
)(
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [11:0] x,
  input  logic signed [11:0] y,
  output logic               busy,
  output logic               done,
  output logic        [11:0] r_theta
);

  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(ANGLE_STEPS - 1);
  localparam logic signed [P_W-1:0] R_MAX_P  = P_W'(R_MAX);
  localparam logic signed [P_W-1:0] P_MIN    = {1'b1, {(P_W-1){1'b0}}};

  state_e                    state_q, state_d;
  logic signed [XY_W-1:0]    x_q, x_d;
  logic signed [XY_W-1:0]    y_q, y_d;
  logic        [IDX_W-1:0]   idx_q, idx_d;
  logic signed [P_W-1:0]     best_p_q, best_p_d;
  logic        [IDX_W-1:0]   best_idx_q, best_idx_d;
  logic        [11:0]        r_theta_q, r_theta_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic signed [TRIG_W-1:0]  cos_w, sin_w;
  logic signed [P_W-1:0]     x_ext, y_ext, cos_ext, sin_ext, p;

  trig_lut_15 u_trig (
    .idx_i (idx_q),
    .cos_o (cos_w),
    .sin_o (sin_w)
  );

  // Operands widened to the projection width; the true sum always fits.
  assign x_ext   = {{(P_W-XY_W){x_q[XY_W-1]}}, x_q};
  assign y_ext   = {{(P_W-XY_W){y_q[XY_W-1]}}, y_q};
  assign cos_ext = {{(P_W-TRIG_W){cos_w[TRIG_W-1]}}, cos_w};
  assign sin_ext = {{(P_W-TRIG_W){sin_w[TRIG_W-1]}}, sin_w};
  assign p       = x_ext * cos_ext + y_ext * sin_ext;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    idx_d      = idx_q;
    best_p_d   = best_p_q;
    best_idx_d = best_idx_q;
    r_theta_d  = r_theta_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d        = x;
          y_d        = y[XY_W-1] ? '0 : y;
          idx_d      = '0;
          best_p_d   = P_MIN;
          best_idx_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (p > best_p_q) begin
          best_p_d   = p;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        // Result is formed from the post-compare best so it lands with done.
        if (idx_q == LAST_IDX) begin
          r_theta_d[TH_MSB:TH_LSB] = best_idx_d;
          r_theta_d[R_MSB:R_LSB]   = sat_r(best_p_d, COS_SCALE_SHIFT, R_MAX_P);
          done_d                   = 1'b1;
          state_d                  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      idx_q      <= '0;
      best_p_q   <= '0;
      best_idx_q <= '0;
      r_theta_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      idx_q      <= idx_d;
      best_p_q   <= best_p_d;
      best_idx_q <= best_idx_d;
      r_theta_q  <= r_theta_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign r_theta = r_theta_q;

endmodule
